// File: rtl/mdu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu_iter                                                      |
// | Purpose  : Iterative multiply/divide unit with architectural HI/LO       |
// |            registers (MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI/MTLO).     |
// |            Works on operand magnitudes, one bit per clock, and applies   |
// |            sign correction in a final FIX cycle.                         |
// | Ports    : clk, rst       - clock, synchronous active-high reset        |
// |            start, op      - launch request (00 MULT, 01 MULTU,          |
// |                             10 DIV, 11 DIVU), sampled when idle          |
// |            a, b           - multiplicand/dividend, multiplier/divisor    |
// |            hi_we, lo_we,  - MTHI/MTLO write strobes and data, honoured  |
// |            wdata            only while idle                              |
// |            busy, done     - operation in progress, one-cycle completion |
// |            div_zero       - last completed op was a divide by zero       |
// |            hi, lo         - architectural HI/LO registers                |
// | Options  : MDU_EARLY_TERM_EN - multiply leaves CALC as soon as the       |
// |            remaining multiplier bits are all zero                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_PREP = 2'd1;
    localparam logic [1:0] c_S_CALC = 2'd2;
    localparam logic [1:0] c_S_FIX  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic               r_is_div;
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // dividend was negative
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;     // divisor, or shifting multiplier
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    // Operand conditioning at accept time
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & a[WIDTH-1];
    assign w_sign_b = w_signed & b[WIDTH-1];
    // |MIN| stays MIN as an unsigned pattern, which is the correct magnitude.
    assign w_abs_a  = w_sign_a ? -a : a;
    assign w_abs_b  = w_sign_b ? -b : b;

    // Restoring divide step: the shifted partial remainder needs one extra
    // bit, and the borrow out of the subtraction decides the quotient bit.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mag_b};

    // Sign-corrected results
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_a_orig;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;
    // Reconstructs the original dividend bit pattern for divide-by-zero.
    assign w_a_orig   = r_neg_rem ? -r_mag_a : r_mag_a;

    // CALC exit condition
    logic w_cnt_last;
    logic w_calc_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
`ifdef MDU_EARLY_TERM_EN
    // Multiplier shifted this cycle has no set bits left above bit 0.
    assign w_calc_last = w_cnt_last | (~r_is_div & (r_mag_b[WIDTH-1:1] == '0));
`else
    assign w_calc_last = w_cnt_last;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_state_next = c_S_PREP;
            c_S_PREP: w_state_next = c_S_CALC;
            c_S_CALC: if (w_calc_last) w_state_next = c_S_FIX;
            c_S_FIX:  w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
                        r_b_zero  <= (b == '0);
                        r_mag_a   <= w_abs_a;
                        r_mag_b   <= w_abs_b;
                    end
                end
                c_S_PREP: begin
                    if (r_is_div) begin
                        r_rem <= '0;
                        r_quo <= r_mag_a;
                    end else begin
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, r_mag_a};
                    end
                    r_cnt <= '0;
                end
                c_S_CALC: begin
                    if (r_is_div) begin
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (r_mag_b[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_mag_b <= r_mag_b >> 1;
                    end
                    r_cnt <= w_calc_last ? '0 : (r_cnt + c_CNT_ONE);
                end
                c_S_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_b_zero) begin
                        r_hi <= w_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_div_zero <= r_is_div & r_b_zero;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != c_S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire
